cacheline_burst_adaptor: RTL and testbench
==========================================

Name: cacheline_burst_adaptor

Overview:
- Memory-side responder for the L1 caches' pmem interface.
- Accepts one 256-bit cacheline read or write from a cache controller (pmem_read/pmem_write/pmem_address/pmem_wdata).
- Serves each request as a 4-beat, 64-bit burst on the physical memory bus.
- Returns pmem_rdata/pmem_resp to the cache.
- Sits between each Icache/Dcache pmem port and the arbiter/DRAM model.

Parameters:
- s_offset, 5, byte-offset bits of a cacheline; the burst address clears these bits.
- s_beat, 64, burst beat width in bits.
- num_beats, 4, beats per line (256 / s_beat).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pmem_read  in  1  cache requests line fill; held until pmem_resp
- pmem_write  in  1  cache requests line writeback; held until pmem_resp
- pmem_address  in  32  line address from cache
- pmem_wdata  in  256  line to write (llc_cacheline)
- pmem_rdata  out  256  filled line (llc_cacheline)
- pmem_resp  out  1  one-cycle completion pulse to cache
- burst_read_o  out  1  memory read request
- burst_write_o  out  1  memory write request
- burst_address_o  out  32  line-aligned burst address
- burst_o  out  64  write beat data
- burst_i  in  64  read beat data
- burst_resp_i  in  1  memory beat strobe; one per beat

Behaviour:
- Clocking: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state IDLE, beat counter 0, all outputs 0 (pmem_rdata 0, burst_address_o 0).
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - pmem_write=1 → latch address (low s_offset bits forced 0) and wdata; go to WR_BURST.
  - Else pmem_read=1 → latch address; go to RD_BURST.
  - Both asserted → write wins (writeback before fill); the read is served on the next acceptance.
  - burst_resp_i in IDLE is ignored.
- RD_BURST:
  - burst_read_o=1 every cycle in state.
  - Each cycle with burst_resp_i=1: burst_i stored into line slice [64*k +: 64], k = beat counter; k increments.
  - On beat k=num_beats-1 → DONE.
  - Cycles with burst_resp_i=0 stall without loss; beats need not be consecutive.
- WR_BURST:
  - burst_write_o=1; burst_o = latched wdata slice k.
  - burst_resp_i=1 consumes beat k and advances k.
  - Last beat → DONE.
- DONE:
  - pmem_resp=1 for exactly this cycle; pmem_rdata holds the assembled line (reads).
  - burst_read_o/burst_write_o = 0.
  - Next state IDLE unconditionally, so a request still high in the resp cycle is not re-accepted until the following cycle.
- Latency: request seen in IDLE at cycle N; burst request visible N+1; with burst_resp_i high on 4 consecutive cycles starting N+1, pmem_resp at N+5.
- pmem_rdata is updated only by read bursts. It holds its value after a write and between requests.
- burst_address_o is stable from acceptance through DONE.
- Beat counter wraps to 0 on entering DONE.
- rst mid-burst: immediate return to IDLE with reset values. The partial line is discarded. The memory model must be reset concurrently.
- Cache changing pmem_address/pmem_wdata mid-request has no effect (latched values used).
- pmem_read/pmem_write dropped mid-burst: the burst still completes and pulses pmem_resp.

Decomposition:
- rv32i_types / shared package: llc_cacheline (256-bit), a burst_beat_t 64-bit typedef, and a burst_state_t enum {IDLE, RD_BURST, WR_BURST, DONE}.
- Single module; no sub-module.
- Beat-slice select is an indexed part-select, not a separate mux block.

Test Plan:
- Read fill: pmem_read, address 0x0000_1234; memory returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on 4 consecutive resp cycles. Required: burst_address_o=0x0000_1220; pmem_rdata = {0x4444…,0x3333…,0x2222…,0x1111…}; pmem_resp exactly one cycle, at N+5.
- Writeback: pmem_write, address 0x8000_00E0, wdata beats A,B,C,D. Required: burst_o sequence A,B,C,D, each advancing only on burst_resp_i; burst_write_o low in DONE; pmem_rdata unchanged.
- Stalled read: burst_resp_i pattern 1,0,0,1,1,0,1. Required: correct line assembled; pmem_resp the cycle after the 4th strobe.
- Simultaneous pmem_read and pmem_write at 0x100: write burst first; read accepted only after the DONE cycle; two distinct pmem_resp pulses.
- Back-to-back: request held high through pmem_resp. Required: no second burst until one IDLE cycle passes; a new address is re-latched.
- Reset after beat 2 of a read: all outputs 0 next cycle; a subsequent fill at 0x40 completes normally with counter starting at 0.

Source files
------------

// File: rtl/cacheline_burst_adaptor_pkg.sv
// Purpose: shared types for the cacheline <-> 64-bit burst adaptor.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package cacheline_burst_adaptor_pkg;

   localparam int s_offset  = 5;
   localparam int s_beat    = 64;
   localparam int num_beats = 4;
   localparam int line_w    = s_beat * num_beats;

   typedef logic [line_w-1:0]              llc_cacheline;
   typedef logic [s_beat-1:0]              burst_beat_t;
   typedef logic [$clog2(num_beats)-1:0]   beat_idx_t;
   typedef logic [$clog2(line_w)-1:0]      beat_base_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } burst_state_t;

   // Clear the byte-offset bits so the burst starts on a line boundary.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & ~((32'd1 << s_offset) - 32'd1);
   endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Purpose: serves one 256-bit cache line request as a 4-beat 64-bit memory burst.
// Latency: accept at N, burst request at N+1, pmem_resp at N+5 with no memory stalls.
// Backpressure: each beat waits for burst_resp_i; stall cycles lose nothing.
module cacheline_burst_adaptor
   import cacheline_burst_adaptor_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                pmem_read,
   input  logic                pmem_write,
   input  logic [31:0]         pmem_address,
   input  llc_cacheline        pmem_wdata,
   output llc_cacheline        pmem_rdata,
   output logic                pmem_resp,
   output logic                burst_read_o,
   output logic                burst_write_o,
   output logic [31:0]         burst_address_o,
   output burst_beat_t         burst_o,
   input  burst_beat_t         burst_i,
   input  logic                burst_resp_i
);

   localparam beat_idx_t last_beat = beat_idx_t'(num_beats - 1);

   burst_state_t  state;
   beat_idx_t     beat_cnt;
   beat_base_t    beat_base;
   llc_cacheline  wdata_q;
   llc_cacheline  line_q;
   llc_cacheline  line_nxt;

   // Bit offset of the current beat inside the line (beat index times beat width).
   assign beat_base = {beat_cnt, {$clog2(s_beat){1'b0}}};

   // Write data always comes from the latched line, never from the live cache port.
   assign burst_o = wdata_q[beat_base +: s_beat];

   // Line being assembled with the incoming read beat merged into its slot.
   always_comb begin
      line_nxt = line_q;
      line_nxt[beat_base +: s_beat] = burst_i;
   end

   // Request acceptance, beat sequencing and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         beat_cnt        <= '0;
         wdata_q         <= '0;
         line_q          <= '0;
         pmem_rdata      <= '0;
         pmem_resp       <= 1'b0;
         burst_read_o    <= 1'b0;
         burst_write_o   <= 1'b0;
         burst_address_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               // Writeback takes priority so a dirty victim leaves before the fill.
               if (pmem_write) begin
                  burst_address_o <= line_align(pmem_address);
                  wdata_q         <= pmem_wdata;
                  burst_write_o   <= 1'b1;
                  state           <= WR_BURST;
               end else if (pmem_read) begin
                  burst_address_o <= line_align(pmem_address);
                  burst_read_o    <= 1'b1;
                  state           <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (burst_resp_i) begin
                  line_q <= line_nxt;
                  if (beat_cnt == last_beat) begin
                     pmem_rdata   <= line_nxt;
                     burst_read_o <= 1'b0;
                     pmem_resp    <= 1'b1;
                     beat_cnt     <= '0;
                     state        <= DONE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            WR_BURST: begin
               if (burst_resp_i) begin
                  if (beat_cnt == last_beat) begin
                     burst_write_o <= 1'b0;
                     pmem_resp     <= 1'b1;
                     beat_cnt      <= '0;
                     state         <= DONE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               // Always pass through IDLE so a request still held here is not re-taken.
               pmem_resp <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Purpose: directed self-checking bench for cacheline_burst_adaptor.
// Latency: a transaction-level model predicts the outputs of every cycle.
// Backpressure: the memory side is driven from per-cycle strobe patterns.
module tb_cacheline_burst_adaptor;

   logic          clk = 1'b0;
   logic          rst;
   logic          pmem_read;
   logic          pmem_write;
   logic [31:0]   pmem_address;
   logic [255:0]  pmem_wdata;
   logic [255:0]  pmem_rdata;
   logic          pmem_resp;
   logic          burst_read_o;
   logic          burst_write_o;
   logic [31:0]   burst_address_o;
   logic [63:0]   burst_o;
   logic [63:0]   burst_i;
   logic          burst_resp_i;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   cacheline_burst_adaptor dut (
      .clk             (clk),
      .rst             (rst),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp),
      .burst_read_o    (burst_read_o),
      .burst_write_o   (burst_write_o),
      .burst_address_o (burst_address_o),
      .burst_o         (burst_o),
      .burst_i         (burst_i),
      .burst_resp_i    (burst_resp_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // One outstanding line transfer: how many beats the memory has acknowledged,
   // plus a one-cycle completion flag.
   bit           m_busy, m_wr, m_done;
   int           m_cnt;
   logic [31:0]  m_addr;
   logic [63:0]  m_wbeats [4];
   logic [63:0]  m_rbeats [4];
   logic [255:0] m_rdata;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_wr = 0; m_done = 0; m_cnt = 0;
         m_addr = '0; m_rdata = '0;
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_busy) begin
         if (pmem_write || pmem_read) begin
            m_busy = 1;
            m_wr   = pmem_write;
            m_addr = pmem_address - (pmem_address % 32);
            m_cnt  = 0;
            for (int i = 0; i < 4; i++) m_wbeats[i] = 64'(pmem_wdata >> (64 * i));
         end
      end else if (burst_resp_i) begin
         if (!m_wr) m_rbeats[m_cnt] = burst_i;
         m_cnt++;
         if (m_cnt == 4) begin
            m_busy = 0;
            m_done = 1;
            if (!m_wr) m_rdata = {m_rbeats[3], m_rbeats[2], m_rbeats[1], m_rbeats[0]};
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("burst_read_o",    256'(burst_read_o),    256'(m_busy && !m_wr));
         chk("burst_write_o",   256'(burst_write_o),   256'(m_busy && m_wr));
         chk("pmem_resp",       256'(pmem_resp),       256'(m_done));
         chk("burst_address_o", 256'(burst_address_o), 256'(m_addr));
         chk("pmem_rdata",      pmem_rdata,            m_rdata);
         if (m_busy && m_wr) chk("burst_o", 256'(burst_o), 256'(m_wbeats[m_cnt]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive the memory side from a strobe pattern (bit 0 first); beats come from rline.
   task automatic serve(input logic [15:0] pat, input int len, input logic [255:0] rline);
      int k = 0;
      for (int i = 0; i < len; i++) begin
         burst_resp_i = pat[i];
         burst_i      = pat[i] ? rline[64 * (k & 3) +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
         if (pat[i]) k++;
         tick();
      end
      burst_resp_i = 1'b0;
      burst_i      = '0;
   endtask

   localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] WD = {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                                  64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
   localparam logic [255:0] L3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                  64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_1E1E_2D2D_3C3C};
   localparam logic [255:0] L4 = {64'h4000_0000_0000_0004, 64'h3000_0000_0000_0003,
                                  64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001};
   localparam logic [255:0] L5 = {64'h0000_0000_5555_0004, 64'h0000_0000_5555_0003,
                                  64'h0000_0000_5555_0002, 64'h0000_0000_5555_0001};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
      pmem_address = '0; pmem_wdata = '0; burst_i = '0; burst_resp_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      chk("rst_rdata", pmem_rdata, 256'd0);
      chk("rst_addr",  256'(burst_address_o), 256'd0);
      chk("rst_resp",  256'(pmem_resp), 256'd0);
      chk("rst_rd",    256'(burst_read_o), 256'd0);
      chk("rst_wr",    256'(burst_write_o), 256'd0);
      tick();

      // 1: read fill, no stalls: resp exactly 5 cycles after acceptance
      pmem_read = 1'b1; pmem_address = 32'h0000_1234;
      tick();
      chk("t1_rd_vis", 256'(burst_read_o), 256'd1);
      chk("t1_addr",   256'(burst_address_o), 256'h1220);
      serve(16'b1111, 4, L1);
      chk("t1_resp",   256'(pmem_resp), 256'd1);
      chk("t1_rdata",  pmem_rdata, L1);
      pmem_read = 1'b0;
      tick();
      chk("t1_resp_off", 256'(pmem_resp), 256'd0);

      // 2: writeback with stalls; live port scribbled after acceptance
      pmem_write = 1'b1; pmem_address = 32'h8000_00E0; pmem_wdata = WD;
      tick();
      pmem_address = 32'hFFFF_FFFF; pmem_wdata = '1;
      chk("t2_wr_vis", 256'(burst_write_o), 256'd1);
      chk("t2_beatA",  256'(burst_o), 256'(64'hAAAA_0000_AAAA_0000));
      serve(16'b110101, 6, '0);
      chk("t2_resp",   256'(pmem_resp), 256'd1);
      chk("t2_wr_done", 256'(burst_write_o), 256'd0);
      chk("t2_addr",   256'(burst_address_o), 256'h8000_00E0);
      chk("t2_rdata_kept", pmem_rdata, L1);
      pmem_write = 1'b0;
      tick();

      // 3: stalled read, strobes 1,0,0,1,1,0,1
      pmem_read = 1'b1; pmem_address = 32'h0000_0A5F;
      tick();
      serve(16'b1011001, 7, L3);
      chk("t3_resp",  256'(pmem_resp), 256'd1);
      chk("t3_rdata", pmem_rdata, L3);
      pmem_read = 1'b0;
      tick();

      // 4: read and write together: write first, read after a full IDLE cycle
      pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0100; pmem_wdata = WD;
      tick();
      chk("t4_wr_first", 256'(burst_write_o), 256'd1);
      chk("t4_no_rd",    256'(burst_read_o), 256'd0);
      serve(16'b1111, 4, '0);
      chk("t4_resp_w", 256'(pmem_resp), 256'd1);
      pmem_write = 1'b0;
      tick();
      chk("t4_idle_gap", 256'(burst_read_o), 256'd0);
      tick();
      chk("t4_rd_next", 256'(burst_read_o), 256'd1);
      serve(16'b1111, 4, L4);
      chk("t4_resp_r",  256'(pmem_resp), 256'd1);
      chk("t4_rdata",   pmem_rdata, L4);
      pmem_read = 1'b0;
      tick();

      // 5: back-to-back, request held through resp with a new address
      pmem_read = 1'b1; pmem_address = 32'h0000_2000;
      tick();
      serve(16'b1111, 4, L1);
      chk("t5_resp", 256'(pmem_resp), 256'd1);
      pmem_address = 32'h0000_3047;
      tick();
      chk("t5_gap_rd", 256'(burst_read_o), 256'd0);
      tick();
      chk("t5_rd2",   256'(burst_read_o), 256'd1);
      chk("t5_addr2", 256'(burst_address_o), 256'h3040);
      serve(16'b1111, 4, L3);
      chk("t5_rdata2", pmem_rdata, L3);
      pmem_read = 1'b0;
      tick();

      // 6: reset after two beats of a read, then a clean fill at 0x40
      pmem_read = 1'b1; pmem_address = 32'h0000_5000;
      tick();
      serve(16'b11, 2, L4);
      rst = 1'b1; pmem_read = 1'b0;
      tick();
      rst = 1'b0;
      chk("t6_rdata0", pmem_rdata, 256'd0);
      chk("t6_addr0",  256'(burst_address_o), 256'd0);
      chk("t6_rd0",    256'(burst_read_o), 256'd0);
      chk("t6_resp0",  256'(pmem_resp), 256'd0);
      pmem_read = 1'b1; pmem_address = 32'h0000_0040;
      tick();
      chk("t6_addr",  256'(burst_address_o), 256'h40);
      serve(16'b1111, 4, L5);
      chk("t6_resp",  256'(pmem_resp), 256'd1);
      chk("t6_rdata", pmem_rdata, L5);
      pmem_read = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
